// File: rtl/bus_pkg.sv
// Shared constants and types for the data-bus request router.
// Target numbering here must match the address decoder's memory map.
package bus_pkg;

    localparam int NUM_TARGETS = 4;
    localparam int TGT_W       = 2;

    localparam logic [TGT_W-1:0] TGT_RAM   = 2'd0;
    localparam logic [TGT_W-1:0] TGT_ROM   = 2'd1;
    localparam logic [TGT_W-1:0] TGT_GPIO  = 2'd2;
    localparam logic [TGT_W-1:0] TGT_TIMER = 2'd3;

    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } bus_demux_state_t;

endpackage

// File: rtl/bus_addr_decode.sv
// Memory-map decode: top address bits to target index and one-hot select.
// Kept apart from the router FSM so the map can change on its own.
module bus_addr_decode
    import bus_pkg::*;
(
    input  logic [TGT_W-1:0]       addr_hi,
    output logic [TGT_W-1:0]       tgt,
    output logic [NUM_TARGETS-1:0] sel
);

    always_comb begin
        tgt = addr_hi;
        sel = '0;
        unique case (addr_hi)
            TGT_RAM:   sel = 4'b0001;
            TGT_ROM:   sel = 4'b0010;
            TGT_GPIO:  sel = 4'b0100;
            TGT_TIMER: sel = 4'b1000;
            default:   sel = '0;
        endcase
    end

endmodule

// File: rtl/bus_demux4.sv
// One-outstanding request router from the LSU to RAM/ROM/GPIO/timer.
// Optional response timeout enabled by defining BUS_DEMUX_TIMEOUT_EN.
module bus_demux4
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          m_req_valid,
    output logic                          m_req_ready,
    input  logic [ADDR_WIDTH-1:0]         m_addr,
    input  logic                          m_we,
    input  logic [DATA_WIDTH-1:0]         m_wdata,
    output logic                          m_rsp_valid,
    output logic [DATA_WIDTH-1:0]         m_rdata,
    output logic                          m_err,
    output logic [NUM_TARGETS-1:0]        s_req_valid,
    input  logic [NUM_TARGETS-1:0]        s_req_ready,
    output logic [ADDR_WIDTH-1:0]         s_addr,
    output logic                          s_we,
    output logic [DATA_WIDTH-1:0]         s_wdata,
    input  logic [NUM_TARGETS-1:0]        s_rsp_valid,
    input  logic [NUM_TARGETS*DATA_WIDTH-1:0] s_rdata
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    bus_demux_state_t        state_q, state_d;
    logic [TGT_W-1:0]        tgt_q, tgt_d;
    logic [NUM_TARGETS-1:0]  req_vld_q, req_vld_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    rsp_vld_q, rsp_vld_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic [TGT_W-1:0]        dec_tgt;
    logic [NUM_TARGETS-1:0]  dec_sel;
    logic [DATA_WIDTH-1:0]   lane [NUM_TARGETS];

    bus_addr_decode u_dec (
        .addr_hi (m_addr[ADDR_WIDTH-1 -: TGT_W]),
        .tgt     (dec_tgt),
        .sel     (dec_sel)
    );

    for (genvar i = 0; i < NUM_TARGETS; i++) begin : g_lane
        assign lane[i] = s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

`ifdef BUS_DEMUX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             limit_hit;
`endif

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        req_vld_d = req_vld_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        rsp_vld_d = 1'b0;
        rdata_d   = rdata_q;
`ifdef BUS_DEMUX_TIMEOUT_EN
        err_d     = err_q;
        cnt_d     = cnt_q;
        limit_hit = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (m_req_valid) begin
                    addr_d    = m_addr;
                    we_d      = m_we;
                    wdata_d   = m_wdata;
                    tgt_d     = dec_tgt;
                    req_vld_d = dec_sel;
                    state_d   = REQ;
`ifdef BUS_DEMUX_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            REQ: begin
                if (s_req_ready[tgt_q]) begin
                    req_vld_d = '0;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (s_rsp_valid[tgt_q]) begin
                    rsp_vld_d = 1'b1;
                    rdata_d   = lane[tgt_q];
                    state_d   = IDLE;
`ifdef BUS_DEMUX_TIMEOUT_EN
                    err_d     = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef BUS_DEMUX_TIMEOUT_EN
        // A real response landing on the limit cycle takes priority.
        if (state_q != IDLE) begin
            cnt_d     = cnt_q + CNT_W'(1);
            limit_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
            if (limit_hit && !(state_q == RESP && s_rsp_valid[tgt_q])) begin
                rsp_vld_d = 1'b1;
                err_d     = 1'b1;
                rdata_d   = DATA_WIDTH'(ERR_DATA);
                req_vld_d = '0;
                state_d   = IDLE;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tgt_q     <= '0;
            req_vld_q <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            rsp_vld_q <= 1'b0;
            rdata_q   <= '0;
`ifdef BUS_DEMUX_TIMEOUT_EN
            err_q     <= 1'b0;
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            req_vld_q <= req_vld_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            rsp_vld_q <= rsp_vld_d;
            rdata_q   <= rdata_d;
`ifdef BUS_DEMUX_TIMEOUT_EN
            err_q     <= err_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign m_req_ready = (state_q == IDLE);
    assign m_rsp_valid = rsp_vld_q;
    assign m_rdata     = rdata_q;
    assign s_req_valid = req_vld_q;
    assign s_addr      = addr_q;
    assign s_we        = we_q;
    assign s_wdata     = wdata_q;
`ifdef BUS_DEMUX_TIMEOUT_EN
    assign m_err       = err_q;
`else
    assign m_err       = 1'b0;
`endif

endmodule

// File: tb/tb_bus_demux4.sv
// Self-checking bench for bus_demux4: table vectors, random transactions
// against a latency/data model, and hand-written reset/stray/timeout cases.
module tb_bus_demux4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         m_req_valid;
    logic         m_req_ready;
    logic [31:0]  m_addr;
    logic         m_we;
    logic [31:0]  m_wdata;
    logic         m_rsp_valid;
    logic [31:0]  m_rdata;
    logic         m_err;
    logic [3:0]   s_req_valid;
    logic [3:0]   s_req_ready;
    logic [31:0]  s_addr;
    logic         s_we;
    logic [31:0]  s_wdata;
    logic [3:0]   s_rsp_valid;
    logic [127:0] s_rdata;

    int n_pass = 0;
    int n_total = 0;

    bus_demux4 #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m_req_valid (m_req_valid),
        .m_req_ready (m_req_ready),
        .m_addr      (m_addr),
        .m_we        (m_we),
        .m_wdata     (m_wdata),
        .m_rsp_valid (m_rsp_valid),
        .m_rdata     (m_rdata),
        .m_err       (m_err),
        .s_req_valid (s_req_valid),
        .s_req_ready (s_req_ready),
        .s_addr      (s_addr),
        .s_we        (s_we),
        .s_wdata     (s_wdata),
        .s_rsp_valid (s_rsp_valid),
        .s_rdata     (s_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [95:0] act,
                         input logic [95:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        m_req_valid = 1'b0;
        s_req_ready = '0;
        s_rsp_valid = '0;
        s_rdata     = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic drive_strays();
        s_req_ready = 4'($urandom);
        s_rsp_valid = 4'($urandom);
        s_rdata     = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Caller is positioned 1ns after a rising edge with the router idle.
    task automatic do_txn(input logic [31:0] addr, input logic we,
                          input logic [31:0] wdata, input int w1,
                          input int w2, input logic [31:0] rdata,
                          input logic [3:0] exp_sel, input int exp_lat);
        int t, cyc, cnt;
        bit ph, hold_ok, done;
        t = int'(addr[31:30]);
        check("accept_ready", 96'(m_req_ready), 96'(1));
        idle_inputs();
        m_req_valid = 1'b1;
        m_addr      = addr;
        m_we        = we;
        m_wdata     = wdata;
        @(posedge clk); #1;
        m_req_valid = 1'b0;
        m_addr      = $urandom;
        m_we        = 1'($urandom);
        m_wdata     = $urandom;
        check("s_bus", {s_addr, 31'b0, s_we, s_wdata},
              {addr, 31'b0, we, wdata});
        cyc = 1; cnt = 0; ph = 0; hold_ok = 1; done = 0;
        while (!done && cyc < 64) begin
            if (m_rsp_valid) begin
                done = 1;
            end else begin
                if (m_req_ready || s_req_valid !== (ph ? 4'b0 : exp_sel))
                    hold_ok = 0;
                drive_strays();
                if (!ph) begin
                    s_req_ready[t] = (cnt >= w1);
                    s_rsp_valid[t] = 1'($urandom);
                end else begin
                    s_req_ready[t] = 1'($urandom);
                    s_rsp_valid[t] = (cnt >= w2);
                    if (cnt >= w2) s_rdata[t*32 +: 32] = rdata;
                end
                @(posedge clk); #1;
                cyc++;
                if (!ph && cnt >= w1) begin
                    ph  = 1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
        end
        check("rsp_seen", 96'(done), 96'(1));
        check("latency", 96'(cyc), 96'(exp_lat));
        check("rdata", 96'(m_rdata), 96'(rdata));
        check("err", 96'(m_err), 96'(0));
        check("ready_at_rsp", 96'(m_req_ready), 96'(1));
        check("hold", 96'(hold_ok), 96'(1));
        idle_inputs();
        @(posedge clk); #1;
        check("pulse_len", {63'b0, m_rsp_valid, m_rdata}, {64'b0, rdata});
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          w1;
        int          w2;
        logic [31:0] rdata;
        logic [3:0]  exp_sel;
        int          exp_lat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [31:0] a, wd, rd;
        int w1, w2, cyc;
        bit seen;

        rst_n       = 1'b0;
        m_req_valid = 1'b0;
        m_addr      = '0;
        m_we        = 1'b0;
        m_wdata     = '0;
        s_req_ready = '0;
        s_rsp_valid = '0;
        s_rdata     = '0;

        vecs[0] = '{32'h0000_0010, 1'b0, 32'h0, 0, 0, 32'h1234_5678, 4'b0001, 3};
        vecs[1] = '{32'h8000_0004, 1'b1, 32'hA5, 0, 0, 32'h0BAD_0001, 4'b0100, 3};
        vecs[2] = '{32'hC000_0000, 1'b0, 32'h0, 5, 0, 32'h7777_0003, 4'b1000, 8};
        vecs[3] = '{32'h4000_0100, 1'b0, 32'h0, 0, 2, 32'h0F0F_1234, 4'b0010, 5};
        vecs[4] = '{32'h0000_0040, 1'b1, 32'h5A5A, 3, 3, 32'h3C3C_2211, 4'b0001, 9};

        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs",
              {26'b0, m_req_ready, m_rsp_valid, m_err, s_req_valid, s_we, m_rdata, s_addr},
              {26'b0, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 32'b0, 32'b0});
        check("rst_wdata", 96'(s_wdata), 96'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_ready", {m_req_ready, m_rsp_valid}, {1'b1, 1'b0});

        foreach (vecs[i])
            do_txn(vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].w1,
                   vecs[i].w2, vecs[i].rdata, vecs[i].exp_sel, vecs[i].exp_lat);

        for (int i = 0; i < 20; i++) begin
            a  = $urandom;
            wd = $urandom;
            rd = $urandom;
            w1 = $urandom_range(0, 3);
            w2 = $urandom_range(0, 3);
            do_txn(a, 1'($urandom), wd, w1, w2, rd,
                   4'(1 << a[31:30]), 3 + w1 + w2);
        end

        // Stray response from target 1 while target 0 is pending.
        idle_inputs();
        m_req_valid = 1'b1;
        m_addr      = 32'h0000_0010;
        m_we        = 1'b0;
        @(posedge clk); #1;
        m_req_valid = 1'b0;
        s_req_ready = 4'b0001;
        @(posedge clk); #1;
        s_req_ready = 4'b0000;
        s_rsp_valid = 4'b0010;
        s_rdata[63:32] = 32'h1111_2222;
        @(posedge clk); #1;
        check("stray_ignored", 96'(m_rsp_valid), 96'(0));
        s_rsp_valid = 4'b0001;
        s_rdata[31:0] = 32'hCAFE_F00D;
        @(posedge clk); #1;
        s_rsp_valid = 4'b0000;
        check("stray_then_real", {63'b0, m_rsp_valid, m_rdata},
              {63'b0, 1'b1, 32'hCAFE_F00D});
        @(posedge clk); #1;

        // Reset while waiting in RESP.
        m_req_valid = 1'b1;
        m_addr      = 32'h0000_0020;
        m_we        = 1'b1;
        m_wdata     = 32'h55;
        @(posedge clk); #1;
        m_req_valid = 1'b0;
        s_req_ready = 4'b0001;
        @(posedge clk); #1;
        s_req_ready = 4'b0000;
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs",
              {26'b0, m_req_ready, m_rsp_valid, m_err, s_req_valid, s_we, m_rdata, s_addr},
              {26'b0, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 32'b0, 32'b0});
        @(posedge clk); #1;
        rst_n = 1'b1;
        s_rsp_valid = 4'b0001;
        s_rdata[31:0] = 32'h9999_9999;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            s_rsp_valid = 4'b0000;
            if (m_rsp_valid || !m_req_ready || s_req_valid != 4'b0) seen = 1;
        end
        check("late_rsp_ignored", {m_rdata, 63'(seen)}, {32'b0, 64'b0});

`ifdef BUS_DEMUX_TIMEOUT_EN
        for (int stall = 0; stall < 2; stall++) begin
            idle_inputs();
            check("to_accept", 96'(m_req_ready), 96'(1));
            m_req_valid = 1'b1;
            m_addr      = 32'h4000_0010;
            m_we        = 1'b0;
            @(posedge clk); #1;
            m_req_valid = 1'b0;
            cyc = 1;
            while (!m_rsp_valid && cyc < 50) begin
                s_req_ready = (stall == 0 && cyc == 1) ? 4'b0010 : 4'b0000;
                s_rsp_valid = 4'b0000;
                @(posedge clk); #1;
                cyc++;
            end
            check("to_latency", 96'(cyc), 96'(9));
            check("to_err", 96'(m_err), 96'(1));
            check("to_rdata", 96'(m_rdata), 96'(32'hDEAD_BEEF));
            check("to_idle", {91'b0, m_req_ready, s_req_valid},
                  {91'b0, 1'b1, 4'b0});
            s_req_ready = 4'b0000;
            @(posedge clk); #1;
            check("to_pulse", 96'(m_rsp_valid), 96'(0));
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
